// File: rtl/cpu_regfile.sv
// Integer register file with registered operand read ports, write-first bypass
// from writeback, and a per-register pending scoreboard for RAW hazard detection.
// Register 0 reads as zero, ignores writes and is never marked pending.
module cpu_regfile #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_REGS = 32,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic              hazard_o,
    input  logic              claim_valid_i,
    input  logic [ADDR_W-1:0] claim_addr_i,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i
);

    logic [XLEN-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_pend_d;
    logic [XLEN-1:0]     r_rs1_data;
    logic [XLEN-1:0]     r_rs2_data;
    logic [XLEN-1:0]     w_rs1_val;
    logic [XLEN-1:0]     w_rs2_val;
    logic                w_rs1_haz;
    logic                w_rs2_haz;
    logic                w_wb_en;

    assign w_wb_en = wb_valid_i && (wb_addr_i != '0);

    // Operand selection with write-first bypass, and per-port hazard terms.
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (rs1_addr_i != '0) begin
            w_rs1_val = (wb_valid_i && wb_addr_i == rs1_addr_i) ? wb_data_i
                                                                 : r_regs[rs1_addr_i];
        end
        if (rs2_addr_i != '0) begin
            w_rs2_val = (wb_valid_i && wb_addr_i == rs2_addr_i) ? wb_data_i
                                                                 : r_regs[rs2_addr_i];
        end
        // A same-cycle writeback to the pending register resolves it via the bypass.
        w_rs1_haz = (rs1_addr_i != '0) && r_pend[rs1_addr_i] &&
                    !(wb_valid_i && wb_addr_i == rs1_addr_i);
        w_rs2_haz = (rs2_addr_i != '0) && r_pend[rs2_addr_i] &&
                    !(wb_valid_i && wb_addr_i == rs2_addr_i);
    end

    assign hazard_o = rd_req_i && (w_rs1_haz || w_rs2_haz);

    // Scoreboard next state: claim overrides a same-index writeback clear.
    always_comb begin
        w_pend_d = r_pend;
        if (wb_valid_i) begin
            w_pend_d[wb_addr_i] = 1'b0;
        end
        if (claim_valid_i) begin
            w_pend_d[claim_addr_i] = 1'b1;
        end
        w_pend_d[0] = 1'b0;
    end

    // Architectural register storage; index 0 is never written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Pending bits; reset discards any in-flight claims.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_d;
        end
    end

    // Registered read ports; outputs hold when no read is requested.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else if (rd_req_i) begin
            r_rs1_data <= w_rs1_val;
            r_rs2_data <= w_rs2_val;
        end
    end

    assign rs1_data_o = r_rs1_data;
    assign rs2_data_o = r_rs2_data;

endmodule
